// File: rtl/highlight_pkg.sv
// Shared definitions for the highlight/hysteresis stages: sequencer state
// encoding and the default frame geometry.
package highlight_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_PUSH  = 3'd4,
        DONE     = 3'd5
    } state_e;

    localparam int unsigned DEF_WIDTH       = 720;
    localparam int unsigned DEF_HEIGHT      = 540;
    localparam int unsigned DEF_DATA_W      = 24;
    localparam int unsigned DEF_FRAME_CNT_W = 8;

endpackage

// File: rtl/highlight_frame_sched.sv
// Frame sequencer: loads one frame from the input FIFO into the external
// single-port RAM, then replays it in raster order into the output FIFO.
module highlight_frame_sched
    import highlight_pkg::*;
#(
    parameter  int WIDTH       = DEF_WIDTH,
    parameter  int HEIGHT      = DEF_HEIGHT,
    parameter  int DATA_W      = DEF_DATA_W,
    parameter  int FRAME_CNT_W = DEF_FRAME_CNT_W,
    localparam int N           = WIDTH * HEIGHT,
    localparam int ADDR_W      = $clog2(N)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_empty,
    input  logic [DATA_W-1:0]      in_dout,
    output logic                   in_rd_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   out_full,
    output logic                   out_wr_en,
    output logic [DATA_W-1:0]      out_din,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [2:0]             dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]      pix_reg_q, pix_reg_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    // FIFO handshakes: a pop happens in any cycle with in_rd_en=1, which is only
    // raised when in_empty=0 (show-ahead head is consumed that cycle); a push
    // happens in any cycle with out_wr_en=1, which is only raised when out_full=0.
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        pix_reg_d     = pix_reg_q;
        frame_count_d = frame_count_q;
        busy          = 1'b1;
        in_rd_en      = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        out_wr_en     = 1'b0;
        out_din       = '0;
        frame_done    = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = LOAD;
                    wr_addr_d = '0;
                end
            end
            LOAD: begin
                mem_addr = wr_addr_q;
                if (!in_empty) begin
                    in_rd_en  = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = in_dout;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d   = RD_ISSUE;
                        rd_addr_d = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                mem_addr = rd_addr_q;
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                pix_reg_d = mem_rdata;
                state_d   = RD_PUSH;
            end
            RD_PUSH: begin
                // pix_reg is held while stalled so the pixel is pushed exactly once.
                out_din = pix_reg_q;
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        state_d   = RD_ISSUE;
                    end
                end
            end
            DONE: begin
                frame_done    = 1'b1;
                frame_count_d = frame_count_q + 1'b1;
                state_d       = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            pix_reg_q     <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            pix_reg_q     <= pix_reg_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_highlight_frame_sched.sv
// Bench for highlight_frame_sched on a 4x3 frame: reset/decode vector table,
// then scoreboarded frames covering bubbles, backpressure, reset and back-to-back runs.
module tb_highlight_frame_sched;
  import highlight_pkg::*;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int DATA_W = 24;
  localparam int FCW    = 2;
  localparam int N      = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(N);

  // ---------------- clock / reset / DUT ----------------
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_empty = 1'b1;
  logic [DATA_W-1:0] in_dout = '0;
  logic              in_rd_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_full = 1'b0;
  logic              out_wr_en;
  logic [DATA_W-1:0] out_din;
  logic              busy;
  logic              frame_done;
  logic [FCW-1:0]    frame_count;
  logic [2:0]        dbg_state;

  always #5 clock = ~clock;

  highlight_frame_sched #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_W(DATA_W), .FRAME_CNT_W(FCW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .dbg_state(dbg_state)
  );

  // 1-cycle synchronous single-port RAM
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] in_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [FCW-1:0] exp_fc = '0;
  int  exp_wr_addr = 0;
  bit  load_phase = 0;
  bit  hold_start = 0;
  bit  bubble_mode = 0;
  bit  bubble_phase = 0;
  bit  bp_arm = 0;
  bit  bp_since_push = 0;
  bit  fc_check = 0;
  int  bp_left = 0;
  int  pops = 0;
  int  pushes = 0;
  int  cyc_since_push = 100;
  int  cyc_since_pop = 100;
  int  since_done = 100;
  int  done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({busy, in_rd_en, mem_we, mem_addr, mem_wdata, out_wr_en, out_din,
                frame_done, frame_count, dbg_state});
  endfunction

  task automatic fill(input logic [DATA_W-1:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      in_q.push_back(base + DATA_W'(i));
      exp_q.push_back(base + DATA_W'(i));
    end
  endtask

  task automatic clear_models();
    in_q.delete();
    exp_q.delete();
    exp_fc = '0;
    exp_wr_addr = 0;
    load_phase = 0;
    bp_left = 0;
    bp_arm = 0;
    pops = 0;
    pushes = 0;
    fc_check = 0;
    cyc_since_push = 100;
    cyc_since_pop = 100;
    since_done = 100;
  endtask

  // Called at a falling edge: drive inputs, check outputs, advance one cycle.
  task automatic step();
    if (hold_start && since_done == 2) load_phase = 1;
    bubble_phase = bubble_mode ? ~bubble_phase : 1'b0;
    in_empty = (in_q.size() == 0) || bubble_phase;
    in_dout  = (in_q.size() != 0) ? in_q[0] : '0;
    out_full = (bp_left > 0);
    if (out_full) bp_since_push = 1;
    #1;
    if (fc_check) begin
      chk("frame_count", 64'(frame_count), 64'(exp_fc));
      chk("done_pulse_len", 64'(frame_done), 64'd0);
      fc_check = 0;
    end
    if (since_done == 1) chk("idle_after_done", 64'(busy), 64'd0);
    if (hold_start && since_done == 2) chk("b2b_reload", 64'({busy, in_rd_en}), 64'b11);
    if (load_phase && !in_empty) chk("pop_when_avail", 64'(in_rd_en), 64'd1);
    if (in_rd_en || mem_we) begin
      chk("pop_nonempty", 64'(in_empty), 64'd0);
      chk("we_with_pop", 64'(mem_we), 64'(in_rd_en));
      chk("pop_in_load", 64'(load_phase), 64'd1);
      chk("wr_addr", 64'(mem_addr), 64'(exp_wr_addr));
      chk("wdata", 64'(mem_wdata), 64'(in_dout));
      if (in_q.size() != 0) void'(in_q.pop_front());
      pops++;
      exp_wr_addr++;
      if (exp_wr_addr == N) begin
        exp_wr_addr = 0;
        load_phase = 0;
        cyc_since_pop = 0;
      end
    end
    if (bp_left > 0 && bp_left <= 10) begin
      chk("bp_no_push", 64'(out_wr_en), 64'd0);
      chk("bp_hold_din", 64'(out_din), 64'h5);
    end
    if (out_wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_push", 64'(out_wr_en), 64'd0);
      else chk("out_din", 64'(out_din), 64'(exp_q.pop_front()));
      if (pushes == 0) chk("first_push_lat", 64'(cyc_since_pop), 64'd3);
      else if (!bp_since_push) chk("push_gap", 64'(cyc_since_push), 64'd3);
      if (bp_arm && out_din == DATA_W'(4)) begin
        bp_left = 13;
        bp_arm = 0;
      end
      pushes++;
      cyc_since_push = 0;
      bp_since_push = 0;
    end
    if (frame_done) begin
      chk("done_after_last", 64'(cyc_since_push), 64'd1);
      chk("fc_at_done", 64'(frame_count), 64'(exp_fc));
      chk("pops_per_frame", 64'(pops), 64'(N));
      chk("pushes_per_frame", 64'(pushes), 64'(N));
      exp_fc = exp_fc + 1'b1;
      fc_check = 1;
      pops = 0;
      pushes = 0;
      done_cnt++;
      since_done = 0;
    end
    cyc_since_push++;
    cyc_since_pop++;
    since_done++;
    if (bp_left > 0) bp_left--;
    @(negedge clock);
  endtask

  task automatic run_until_done(input int target, input int budget);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      step();
      c++;
    end
    chk("frame_timeout", 64'(done_cnt), 64'(target));
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] base);
    fill(base, N);
    start = 1'b1;
    step();
    start = 1'b0;
    load_phase = 1;
    run_until_done(done_cnt + 1, 400);
    step();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("reset_outputs", all_outputs(), 64'd0);
    chk("reset_frame_count", 64'(frame_count), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_models();
  endtask

  // ---------------- reset / decode vector table ----------------
  typedef struct {
    logic              rst_n;
    logic              start;
    logic              empty;
    logic              busy;
    logic              rd;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 24'habcdef};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 24'habcdef};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 24'habcdef};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0};

    @(negedge clock);
    for (int i = 0; i < 11; i++) begin
      reset    = vecs[i].rst_n;
      start    = vecs[i].start;
      in_empty = vecs[i].empty;
      in_dout  = 24'habcdef;
      out_full = 1'b0;
      #1;
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
      chk($sformatf("vec%0d_rd", i), 64'(in_rd_en), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_we", i), 64'(mem_we), 64'(vecs[i].we));
      chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(vecs[i].wdata));
      chk($sformatf("vec%0d_quiet", i), 64'({out_wr_en, out_din, frame_done, frame_count}), 64'd0);
      @(negedge clock);
    end
    start = 1'b0;
    clear_models();

    // nominal frame
    run_frame(24'h000001);

    // load bubbles
    bubble_mode = 1;
    run_frame(24'h000001);
    bubble_mode = 0;

    // backpressure while pixel 5 waits
    bp_arm = 1;
    run_frame(24'h000001);
    bp_arm = 0;

    // reset mid-replay after 6 pushes, then a clean frame
    fill(24'h000001, N);
    start = 1'b1;
    step();
    start = 1'b0;
    load_phase = 1;
    for (int c = 0; c < 200 && pushes < 6; c++) step();
    chk("pushes_before_reset", 64'(pushes), 64'd6);
    apply_reset();
    run_frame(24'h000100);

    // start held high for five back-to-back frames
    apply_reset();
    fill(24'h000200, 5 * N);
    hold_start = 1;
    start = 1'b1;
    step();
    load_phase = 1;
    run_until_done(done_cnt + 5, 1000);
    start = 1'b0;
    hold_start = 0;
    step();
    step();

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("in_q_drained", 64'(in_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
